recon_head: RTL and testbench

- Final reconstruction stage directly downstream of the contextual decoder.
- Consumes the decoder's 32-channel feature map one pixel at a time over a valid/ready stream.
- Applies a per-pixel 1x1 convolution (CH_IN -> 3 channels, bias added) using a sequential MAC loop, then clamps each result to the [0, 1.0] fixed-point range.
- Emits reconstructed RGB pixels on a valid/ready stream, counts pixels per frame and pulses done at frame end.

---
 rtl/recon_head.sv | 138 +++++++++++++
 tb/tb_recon_head.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/recon_head.sv
// rtl/recon_head.sv - 1x1 conv reconstruction head: CH_IN features -> clamped RGB per pixel
module recon_head #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int CH_IN      = 32,
    parameter int CH_OUT     = 3,
    parameter int FRAME_PIX  = 4096
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [CH_OUT*CH_IN*DATA_WIDTH-1:0]   weights_flat,
    input  logic [CH_OUT*DATA_WIDTH-1:0]         bias_flat,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [CH_IN*DATA_WIDTH-1:0]          in_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [CH_OUT*DATA_WIDTH-1:0]         out_data,
    output logic                                 busy,
    output logic                                 done
);

    localparam int ACC_W = 2*DATA_WIDTH + $clog2(CH_IN) + 1;
    localparam int IDX_W = (CH_IN > 1) ? $clog2(CH_IN) : 1;
    localparam int CNT_W = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH_IN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_PIX - 1);
    localparam logic signed [ACC_W-1:0] ONE_ACC = {{(ACC_W-1){1'b0}}, 1'b1} << FRAC_BITS;

    typedef enum logic [1:0] {IDLE, WAIT_IN, MAC, OUT} state_t;

    state_t                      state;
    logic [CH_IN*DATA_WIDTH-1:0] x_reg;
    logic [ACC_W-1:0]            acc       [CH_OUT];
    logic [ACC_W-1:0]            acc_nxt   [CH_OUT];
    logic [ACC_W-1:0]            bias_init [CH_OUT];
    logic [DATA_WIDTH-1:0]       w_sel     [CH_OUT];
    logic [2*DATA_WIDTH-1:0]     prod      [CH_OUT];
    logic [DATA_WIDTH-1:0]       x_sel;
    logic [IDX_W-1:0]            idx;
    logic [CNT_W-1:0]            pix_cnt;
    logic [CH_OUT*DATA_WIDTH-1:0] res_nxt;

    // Floor-shift back to FRAC_BITS, then saturate into [0, 1.0].
    function automatic logic [DATA_WIDTH-1:0] clamp_unit(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] r;
        r = a >>> FRAC_BITS;
        if (r < 0)
            return '0;
        else if (r > ONE_ACC)
            return DATA_WIDTH'(ONE_ACC);
        else
            return DATA_WIDTH'(r);
    endfunction

    // Sign-extended operands make the low 2*DATA_WIDTH bits of the unsigned product the exact signed product.
    always_comb begin
        x_sel = x_reg[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
        for (int k = 0; k < CH_OUT; k++) begin
            w_sel[k]     = weights_flat[(k*CH_IN + int'(idx))*DATA_WIDTH +: DATA_WIDTH];
            prod[k]      = {{DATA_WIDTH{w_sel[k][DATA_WIDTH-1]}}, w_sel[k]} *
                           {{DATA_WIDTH{x_sel[DATA_WIDTH-1]}}, x_sel};
            acc_nxt[k]   = acc[k] + {{(ACC_W-2*DATA_WIDTH){prod[k][2*DATA_WIDTH-1]}}, prod[k]};
            bias_init[k] = {{(ACC_W-DATA_WIDTH){bias_flat[k*DATA_WIDTH+DATA_WIDTH-1]}},
                            bias_flat[k*DATA_WIDTH +: DATA_WIDTH]} << FRAC_BITS;
        end
    end

    always_comb begin
        res_nxt = '0;
        for (int k = 0; k < CH_OUT; k++)
            res_nxt[k*DATA_WIDTH +: DATA_WIDTH] = clamp_unit(acc_nxt[k]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_data  <= '0;
            x_reg     <= '0;
            idx       <= '0;
            pix_cnt   <= '0;
            for (int k = 0; k < CH_OUT; k++)
                acc[k] <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WAIT_IN;
                        pix_cnt  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                WAIT_IN: begin
                    if (in_valid && in_ready) begin
                        x_reg    <= in_data;
                        acc      <= bias_init;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_nxt;
                    idx <= idx + 1'b1;
                    // Last tap: the clamp sees acc_nxt so the final product is included.
                    if (idx == IDX_LAST) begin
                        out_data  <= res_nxt;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        if (pix_cnt == CNT_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            pix_cnt  <= pix_cnt + 1'b1;
                            in_ready <= 1'b1;
                            state    <= WAIT_IN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_recon_head.sv
// tb/tb_recon_head.sv - randomized bench for recon_head against a wide-integer reference model
module tb_recon_head;

    localparam int DW = 32;
    localparam int FB = 16;
    localparam int CI = 32;
    localparam int CO = 3;
    localparam int FP = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [CO*CI*DW-1:0] weights_flat = '0;
    logic [CO*DW-1:0]    bias_flat = '0;
    logic [CI*DW-1:0]    in_data = '0;
    logic                in_ready, out_valid, busy, done;
    logic [CO*DW-1:0]    out_data;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int done_cnt = 0;
    int out_hs = 0;

    logic signed [DW-1:0] w [CO][CI];
    logic signed [DW-1:0] b [CO];
    logic [CI*DW-1:0]     d;

    recon_head #(
        .DATA_WIDTH(DW), .FRAC_BITS(FB), .CH_IN(CI), .CH_OUT(CO), .FRAME_PIX(FP)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .weights_flat(weights_flat), .bias_flat(bias_flat),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid && out_ready) out_hs++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact wide sum, floor division by 2^FB, saturate to [0, 1.0].
    function automatic logic [CO*DW-1:0] ref_pix(input logic [CI*DW-1:0] px);
        logic [CO*DW-1:0] r;
        logic signed [127:0] s;
        r = '0;
        for (int k = 0; k < CO; k++) begin
            s = 128'(b[k]) <<< FB;
            for (int c = 0; c < CI; c++)
                s = s + 128'(w[k][c]) * 128'($signed(px[c*DW +: DW]));
            s = s >>> FB;
            if (s < 0)
                r[k*DW +: DW] = '0;
            else if (s > (128'sd1 <<< FB))
                r[k*DW +: DW] = 32'h0001_0000;
            else
                r[k*DW +: DW] = s[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic [CI*DW-1:0] rand_pix(input int range);
        logic [CI*DW-1:0] px;
        for (int c = 0; c < CI; c++) begin
            if (range == 0)
                px[c*DW +: DW] = $urandom();
            else
                px[c*DW +: DW] = DW'(int'($urandom_range(0, 2*range)) - range);
        end
        return px;
    endfunction

    task automatic load_params();
        for (int k = 0; k < CO; k++) begin
            bias_flat[k*DW +: DW] = b[k];
            for (int c = 0; c < CI; c++)
                weights_flat[(k*CI + c)*DW +: DW] = w[k][c];
        end
    endtask

    task automatic set_identity(input int b0, input int b1, input int b2);
        for (int k = 0; k < CO; k++)
            for (int c = 0; c < CI; c++)
                w[k][c] = (c == k) ? 32'sh0001_0000 : 32'sh0;
        b[0] = b0; b[1] = b1; b[2] = b2;
        load_params();
    endtask

    task automatic set_random(input int wr, input int br);
        for (int k = 0; k < CO; k++) begin
            b[k] = DW'(int'($urandom_range(0, 2*br)) - br);
            for (int c = 0; c < CI; c++)
                w[k][c] = DW'(int'($urandom_range(0, 2*wr)) - wr);
        end
        load_params();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_busy", busy, 1'b1);
        check("start_in_ready", in_ready, 1'b1);
    endtask

    task automatic do_pixel(input logic [CI*DW-1:0] px, input int in_gap, input int out_gap,
                            input bit last, input bit start_mid);
        logic [CO*DW-1:0] exp_v;
        int n;
        int hs0;
        exp_v = ref_pix(px);
        repeat (in_gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = px;
        n = 0;
        while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
        check("in_ready_seen", in_ready, 1'b1);
        @(posedge clk); #1;
        hs_cyc   = cyc;
        in_valid = 1'b0;
        in_data  = rand_pix(0);
        check("in_ready_drop", in_ready, 1'b0);
        n = 0;
        while (!out_valid && n < 300) begin
            start = start_mid && (n == 3);
            @(posedge clk); #1; n++;
        end
        start = 1'b0;
        check("out_valid_seen", out_valid, 1'b1);
        check("latency", cyc - hs_cyc, CI);
        check("out_data", out_data, exp_v);
        for (int i = 0; i < out_gap; i++) begin
            start = start_mid && (i == 0);
            @(posedge clk); #1;
            start = 1'b0;
            check("bp_valid", out_valid, 1'b1);
            check("bp_data", out_data, exp_v);
            check("bp_in_ready", in_ready, 1'b0);
        end
        hs0 = out_hs;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("out_valid_drop", out_valid, 1'b0);
        check("one_accept", out_hs - hs0, 1);
        check("done_flag", done, last);
        if (last) begin
            @(posedge clk); #1;
            check("done_pulse_end", done, 1'b0);
            check("busy_idle", busy, 1'b0);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out_data", out_data, 0);
        rst = 1'b1;

        in_valid = 1'b1;
        in_data  = rand_pix(0);
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_in_ready", in_ready, 1'b0);
        end
        check("idle_busy", busy, 1'b0);
        in_valid = 1'b0;

        // Frame A: identity pixel, backpressure, start while busy
        set_identity(0, 0, 0);
        pulse_start();
        d = '0;
        d[0 +: DW]  = 32'h8000;
        d[DW +: DW] = 32'h4000;
        d[2*DW +: DW] = 32'h2000;
        do_pixel(d, 0, 0, 1'b0, 1'b0);
        check("ident_ch0", out_data[0 +: DW], 32'h8000);
        check("ident_ch1", out_data[DW +: DW], 32'h4000);
        check("ident_ch2", out_data[2*DW +: DW], 32'h2000);
        do_pixel(rand_pix(32'h20000), 1, 20, 1'b0, 1'b0);
        do_pixel(rand_pix(32'h20000), 0, 3, 1'b0, 1'b1);
        check("no_early_done", done_cnt, 0);
        check("busy_mid_frame", busy, 1'b1);
        do_pixel(rand_pix(32'h20000), 2, 0, 1'b1, 1'b0);
        check("done_count_a", done_cnt, 1);

        // Frame B: clamp at both ends, then random gaps
        set_identity(-32'sh10000, 32'sh8000, 0);
        pulse_start();
        d = '0;
        d[0 +: DW]  = 32'h4000;
        d[DW +: DW] = 32'h10000;
        do_pixel(d, 0, 0, 1'b0, 1'b0);
        check("clamp_neg", out_data[0 +: DW], 32'h0);
        check("clamp_pos", out_data[DW +: DW], 32'h10000);
        for (int p = 1; p < FP; p++)
            do_pixel(rand_pix(32'h18000), $urandom_range(0, 4), $urandom_range(0, 4), p == FP-1, 1'b0);
        check("done_count_b", done_cnt, 2);

        // Frame C: random weights/bias, one full-range pixel
        set_random(32'h1000, 32'h20000);
        pulse_start();
        do_pixel(rand_pix(0), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
        for (int p = 1; p < FP; p++)
            do_pixel(rand_pix(32'h40000), $urandom_range(0, 5), $urandom_range(0, 5), p == FP-1, 1'b0);
        check("done_count_c", done_cnt, 3);

        // Frame D: reset five cycles into MAC, then a clean frame
        pulse_start();
        in_valid = 1'b1;
        in_data  = rand_pix(0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_out_data", out_data, 0);
        repeat (2) @(posedge clk); #1;
        check("mid_rst_hold_busy", busy, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_no_done", done_cnt, 3);
        check("mid_rst_idle", busy, 1'b0);
        set_random(32'h2000, 32'h10000);
        pulse_start();
        for (int p = 0; p < FP; p++)
            do_pixel(rand_pix(32'h30000), $urandom_range(0, 4), $urandom_range(0, 4), p == FP-1, 1'b0);
        check("done_count_d", done_cnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
